// File: rtl/svc_soc_io_dbg_bridge.sv
// ---------------------------------------------------------------------------
// svc_soc_io_dbg_bridge
//   Host debug bridge: parses command packets arriving on a UART RX byte
//   stream and turns each into one single-beat MMIO access, then returns an
//   acknowledge or the read data on a UART TX byte stream.
//
//   Packets (multi-byte fields little-endian):
//     0x57 'W' addr[4] data[4] -> one write, reply 0x4B 'K'
//     0x52 'R' addr[4]         -> one read,  reply rdata[4]
//     other cmd byte           -> no access, reply 0x45 'E'
//
//   Ports
//     clk, rst_n                  clock, asynchronous active-low reset
//     urx_valid/urx_data/urx_ready  RX byte stream (bridge is the sink)
//     utx_valid/utx_data/utx_ready  TX byte stream (bridge is the source)
//     io_wen/io_waddr/io_wdata/io_wstrb  MMIO write port (1-cycle strobe)
//     io_ren/io_raddr/io_rdata           MMIO read port (1-cycle strobe)
//     busy                        high whenever a packet is in progress
//
//   Parameters
//     RD_LATENCY      0: io_rdata valid in the io_ren cycle, 1: next cycle
//     TIMEOUT_CYCLES  idle cycles allowed between packet bytes, 0 = never
// ---------------------------------------------------------------------------
module svc_soc_io_dbg_bridge #(
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        urx_valid,
    input  logic [7:0]  urx_data,
    output logic        urx_ready,
    output logic        utx_valid,
    output logic [7:0]  utx_data,
    input  logic        utx_ready,
    output logic        io_wen,
    output logic [31:0] io_waddr,
    output logic [31:0] io_wdata,
    output logic [3:0]  io_wstrb,
    output logic        io_ren,
    output logic [31:0] io_raddr,
    input  logic [31:0] io_rdata,
    output logic        busy
);

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] RSP_K = 8'h4B;
    localparam logic [7:0] RSP_E = 8'h45;

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 32'd0) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_ISSUE = 3'd3,
        S_RWAIT = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t            state_q,     state_d;
    logic [1:0]        cnt_q,       cnt_d;
    logic              is_wr_q,     is_wr_d;
    logic              multi_q,     multi_d;
    logic [31:0]       addr_sh_q,   addr_sh_d;
    logic [31:0]       buf_q,       buf_d;
    logic [31:0]       addr_q,      addr_d;
    logic [31:0]       wdata_q,     wdata_d;
    logic [TMO_W-1:0]  tmo_q,       tmo_d;
    logic              urx_ready_q, urx_ready_d;
    logic              utx_valid_q, utx_valid_d;
    logic [7:0]        utx_data_q,  utx_data_d;
    logic              io_wen_q,    io_wen_d;
    logic              io_ren_q,    io_ren_d;
    logic              busy_q,      busy_d;

    logic              byte_acc_s;
    logic              byte_sent_s;

    // Pick byte i (0 = least significant) out of a 32-bit word.
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign byte_acc_s  = urx_valid && urx_ready_q;
    assign byte_sent_s = utx_valid_q && utx_ready;

    // Next-state and next-output computation for the packet FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_wr_d     = is_wr_q;
        multi_d     = multi_q;
        addr_sh_d   = addr_sh_q;
        buf_d       = buf_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tmo_d       = {TMO_W{1'b0}};
        urx_ready_d = urx_ready_q;
        utx_valid_d = utx_valid_q;
        utx_data_d  = utx_data_q;
        io_wen_d    = 1'b0;
        io_ren_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (byte_acc_s) begin
                    cnt_d = 2'd0;
                    if ((urx_data == CMD_W) || (urx_data == CMD_R)) begin
                        is_wr_d = (urx_data == CMD_W);
                        state_d = S_ADDR;
                    end else begin
                        state_d     = S_RESP;
                        urx_ready_d = 1'b0;
                        utx_valid_d = 1'b1;
                        utx_data_d  = RSP_E;
                        multi_d     = 1'b0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_ADDR, S_WDATA: begin
                if (byte_acc_s) begin
                    cnt_d = cnt_q + 2'd1;
                    if (state_q == S_ADDR) begin
                        addr_sh_d = {urx_data, addr_sh_q[31:8]};
                    end else begin
                        buf_d = {urx_data, buf_q[31:8]};
                    end
                    if (cnt_q == 2'd3) begin
                        if (state_q == S_ADDR && is_wr_q) begin
                            state_d = S_WDATA;
                        end else if (state_q == S_ADDR) begin
                            // Read: bus address is latched only now, so the
                            // io address holds its old value while bytes stream in.
                            state_d     = S_ISSUE;
                            urx_ready_d = 1'b0;
                            io_ren_d    = 1'b1;
                            addr_d      = {urx_data, addr_sh_q[31:8]};
                        end else begin
                            state_d     = S_ISSUE;
                            urx_ready_d = 1'b0;
                            io_wen_d    = 1'b1;
                            addr_d      = addr_sh_q;
                            wdata_d     = {urx_data, buf_q[31:8]};
                        end
                    end else begin
                        state_d = state_q;
                    end
                end else if (TIMEOUT_CYCLES == 32'd0) begin
                    tmo_d = {TMO_W{1'b0}};
                end else if (tmo_q == TMO_LAST) begin
                    // Host went silent mid-packet: drop it without access or reply.
                    state_d = S_IDLE;
                    cnt_d   = 2'd0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_ISSUE: begin
                cnt_d = 2'd0;
                if (is_wr_q) begin
                    state_d     = S_RESP;
                    utx_valid_d = 1'b1;
                    utx_data_d  = RSP_K;
                    multi_d     = 1'b0;
                end else if (RD_LATENCY == 32'd0) begin
                    state_d     = S_RESP;
                    buf_d       = io_rdata;
                    utx_valid_d = 1'b1;
                    utx_data_d  = io_rdata[7:0];
                    multi_d     = 1'b1;
                end else begin
                    state_d = S_RWAIT;
                end
            end

            S_RWAIT: begin
                state_d     = S_RESP;
                buf_d       = io_rdata;
                utx_valid_d = 1'b1;
                utx_data_d  = io_rdata[7:0];
                multi_d     = 1'b1;
                cnt_d       = 2'd0;
            end

            S_RESP: begin
                if (byte_sent_s) begin
                    if (!multi_q || (cnt_q == 2'd3)) begin
                        state_d     = S_IDLE;
                        utx_valid_d = 1'b0;
                        urx_ready_d = 1'b1;
                        cnt_d       = 2'd0;
                    end else begin
                        cnt_d      = cnt_q + 2'd1;
                        utx_data_d = byte_sel(buf_q, cnt_q + 2'd1);
                    end
                end else begin
                    state_d = S_RESP;
                end
            end

            default: begin
                state_d     = S_IDLE;
                cnt_d       = 2'd0;
                urx_ready_d = 1'b1;
                utx_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            is_wr_q     <= 1'b0;
            multi_q     <= 1'b0;
            addr_sh_q   <= 32'd0;
            buf_q       <= 32'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            tmo_q       <= {TMO_W{1'b0}};
            urx_ready_q <= 1'b1;
            utx_valid_q <= 1'b0;
            utx_data_q  <= 8'h00;
            io_wen_q    <= 1'b0;
            io_ren_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_wr_q     <= is_wr_d;
            multi_q     <= multi_d;
            addr_sh_q   <= addr_sh_d;
            buf_q       <= buf_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tmo_q       <= tmo_d;
            urx_ready_q <= urx_ready_d;
            utx_valid_q <= utx_valid_d;
            utx_data_q  <= utx_data_d;
            io_wen_q    <= io_wen_d;
            io_ren_q    <= io_ren_d;
            busy_q      <= busy_d;
        end
    end

    assign urx_ready = urx_ready_q;
    assign utx_valid = utx_valid_q;
    assign utx_data  = utx_data_q;
    assign io_wen    = io_wen_q;
    assign io_ren    = io_ren_q;
    assign io_waddr  = addr_q;
    assign io_raddr  = addr_q;
    assign io_wdata  = wdata_q;
    assign io_wstrb  = 4'hF;
    assign busy      = busy_q;

endmodule
